// File: rtl/alu_bus_if.sv
// ALU bus: operands/command from the driver side, registered results and flags back.
interface alu_bus_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [3:0]       cmd;
  logic             ce;
  logic [1:0]       inp_valid;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] res;
  logic             oflow;
  logic             cout;
  logic             g;
  logic             l;
  logic             e;
  logic             err;

  modport master (
    output opa, opb, cmd, ce, inp_valid, mode, cin,
    input  res, oflow, cout, g, l, e, err
  );

  modport slave (
    input  opa, opb, cmd, ce, inp_valid, mode, cin,
    output res, oflow, cout, g, l, e, err
  );
endinterface

// File: rtl/alu_modport.sv
// Single-cycle registered ALU with arithmetic/logical command sets, compare and error flags.
// The result bus floats whenever the previous edge had ce low (outside reset).
module alu_modport #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       reset,
  alu_bus_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] a,
                                                input logic [SHW-1:0] s);
    logic [2*WIDTH-1:0] t;
    t = {a, a} << s;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] a,
                                                 input logic [SHW-1:0] s);
    logic [2*WIDTH-1:0] t;
    t = {a, a} >> s;
    return t[WIDTH-1:0];
  endfunction

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] res_nx;
  logic             oflow_nx, cout_nx, g_nx, l_nx, e_nx, err_nx;
  logic             need_a, need_b, legal;
  logic [WIDTH:0]   tmp;

  logic [WIDTH-1:0] res_p0;
  logic             oflow_p0, cout_p0, g_p0, l_p0, e_p0, err_p0;
  logic             vld_p0;

  always_comb begin
    res_nx   = '0;
    oflow_nx = 1'b0;
    cout_nx  = 1'b0;
    g_nx     = 1'b0;
    l_nx     = 1'b0;
    e_nx     = 1'b0;
    err_nx   = 1'b0;
    need_a   = 1'b0;
    need_b   = 1'b0;
    legal    = 1'b1;
    tmp      = '0;

    // Operand requirements per command
    if (bus.mode) begin
      case (bus.cmd)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd8: begin need_a = 1'b1; need_b = 1'b1; end
        4'd4, 4'd5:                   need_a = 1'b1;
        4'd6, 4'd7:                   need_b = 1'b1;
        default:                      legal  = 1'b0;
      endcase
    end else begin
      case (bus.cmd)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: begin
          need_a = 1'b1;
          need_b = 1'b1;
        end
        4'd6, 4'd8, 4'd9:   need_a = 1'b1;
        4'd7, 4'd10, 4'd11: need_b = 1'b1;
        default:            legal  = 1'b0;
      endcase
    end

    if (!bus.ce) begin
      res_nx = '0;
    end else if (!legal || (need_a && !bus.inp_valid[0]) || (need_b && !bus.inp_valid[1])) begin
      err_nx = 1'b1;
    end else if (bus.mode) begin
      case (bus.cmd)
        4'd0: begin tmp = {1'b0, bus.opa} + {1'b0, bus.opb}; cout_nx = tmp[WIDTH]; end
        4'd1: begin tmp = {1'b0, bus.opa} - {1'b0, bus.opb}; oflow_nx = tmp[WIDTH]; end
        4'd2: begin
          tmp = {1'b0, bus.opa} + {1'b0, bus.opb} + {{WIDTH{1'b0}}, bus.cin};
          cout_nx = tmp[WIDTH];
        end
        // The borrow out of the widened subtraction is exactly opa < opb + cin
        4'd3: begin
          tmp = {1'b0, bus.opa} - {1'b0, bus.opb} - {{WIDTH{1'b0}}, bus.cin};
          oflow_nx = tmp[WIDTH];
        end
        4'd4: begin tmp = {1'b0, bus.opa} + ONE; cout_nx  = tmp[WIDTH]; end
        4'd5: begin tmp = {1'b0, bus.opa} - ONE; oflow_nx = tmp[WIDTH]; end
        4'd6: begin tmp = {1'b0, bus.opb} + ONE; cout_nx  = tmp[WIDTH]; end
        4'd7: begin tmp = {1'b0, bus.opb} - ONE; oflow_nx = tmp[WIDTH]; end
        default: begin
          g_nx = bus.opa >  bus.opb;
          l_nx = bus.opa <  bus.opb;
          e_nx = bus.opa == bus.opb;
        end
      endcase
      if (bus.cmd != 4'd8) res_nx = tmp[WIDTH-1:0];
    end else begin
      case (bus.cmd)
        4'd0:  res_nx = bus.opa & bus.opb;
        4'd1:  res_nx = ~(bus.opa & bus.opb);
        4'd2:  res_nx = bus.opa | bus.opb;
        4'd3:  res_nx = ~(bus.opa | bus.opb);
        4'd4:  res_nx = bus.opa ^ bus.opb;
        4'd5:  res_nx = ~(bus.opa ^ bus.opb);
        4'd6:  res_nx = ~bus.opa;
        4'd7:  res_nx = ~bus.opb;
        4'd8:  res_nx = bus.opa >> 1;
        4'd9:  res_nx = bus.opa << 1;
        4'd10: res_nx = bus.opb >> 1;
        4'd11: res_nx = bus.opb << 1;
        // Out-of-range rotate amount flags err but the rotate result is still returned
        4'd12: begin
          res_nx = rot_left(bus.opa, bus.opb[SHW-1:0]);
          err_nx = |bus.opb[WIDTH-1:SHW];
        end
        default: begin
          res_nx = rot_right(bus.opa, bus.opb[SHW-1:0]);
          err_nx = |bus.opb[WIDTH-1:SHW];
        end
      endcase
    end
  end

  // Stage p0: output registers; vld_p0 high means the result bus is driven
  always_ff @(posedge clk) begin
    if (reset) begin
      res_p0   <= '0;
      oflow_p0 <= 1'b0;
      cout_p0  <= 1'b0;
      g_p0     <= 1'b0;
      l_p0     <= 1'b0;
      e_p0     <= 1'b0;
      err_p0   <= 1'b0;
      vld_p0   <= 1'b1;
    end else begin
      res_p0   <= res_nx;
      oflow_p0 <= oflow_nx;
      cout_p0  <= cout_nx;
      g_p0     <= g_nx;
      l_p0     <= l_nx;
      e_p0     <= e_nx;
      err_p0   <= err_nx;
      vld_p0   <= bus.ce;
    end
  end

  assign bus.res   = vld_p0 ? res_p0 : {WIDTH{1'bz}};
  assign bus.oflow = oflow_p0;
  assign bus.cout  = cout_p0;
  assign bus.g     = g_p0;
  assign bus.l     = l_p0;
  assign bus.e     = e_p0;
  assign bus.err   = err_p0;
endmodule

// File: tb/tb_alu_modport.sv
// Randomised and directed bench for alu_modport against an integer reference model.
module tb_alu_modport;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  alu_bus_if #(.WIDTH(W)) bus ();

  alu_modport #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [5:0]   fl;  // {oflow, cout, g, l, e, err}
  } exp_t;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic exp_t model(input bit rst, input bit ce, input bit mode, input bit cin,
                                 input logic [1:0] v, input logic [3:0] cmd,
                                 input logic [W-1:0] a8, input logic [W-1:0] b8);
    exp_t x;
    int a, b, r, n, c;
    bit of, co, g, l, e, er, na, nb, ok;
    a = int'(a8); b = int'(b8); c = int'(cin);
    r = 0; of = 0; co = 0; g = 0; l = 0; e = 0; er = 0;
    x.fl = '0;
    if (rst) begin x.res = '0; return x; end
    if (!ce) begin x.res = 'z; return x; end
    na = 0; nb = 0; ok = 1;
    if (mode) begin
      if (cmd <= 3 || cmd == 8) begin na = 1; nb = 1; end
      else if (cmd == 4 || cmd == 5) na = 1;
      else if (cmd == 6 || cmd == 7) nb = 1;
      else ok = 0;
    end else begin
      if (cmd <= 5 || cmd == 12 || cmd == 13) begin na = 1; nb = 1; end
      else if (cmd == 6 || cmd == 8 || cmd == 9) na = 1;
      else if (cmd == 7 || cmd == 10 || cmd == 11) nb = 1;
      else ok = 0;
    end
    if (!ok || (na && !v[0]) || (nb && !v[1])) begin
      er = 1;
    end else if (mode) begin
      case (cmd)
        0: begin r = a + b;     co = (r >= M); end
        1: begin r = a - b;     of = (a < b); end
        2: begin r = a + b + c; co = (r >= M); end
        3: begin r = a - b - c; of = (a < b + c); end
        4: begin r = a + 1;     co = (a == M - 1); end
        5: begin r = a - 1;     of = (a == 0); end
        6: begin r = b + 1;     co = (b == M - 1); end
        7: begin r = b - 1;     of = (b == 0); end
        default: begin r = 0; g = (a > b); l = (a < b); e = (a == b); end
      endcase
    end else begin
      case (cmd)
        0:  r = a & b;
        1:  r = ~(a & b);
        2:  r = a | b;
        3:  r = ~(a | b);
        4:  r = a ^ b;
        5:  r = ~(a ^ b);
        6:  r = ~a;
        7:  r = ~b;
        8:  r = a / 2;
        9:  r = a * 2;
        10: r = b / 2;
        11: r = b * 2;
        default: begin
          n = b % W;
          er = (b >= W);
          r = a;
          for (int k = 0; k < n; k++)
            if (cmd == 12) r = ((r * 2) % M) + (r / (M / 2));
            else           r = (r / 2) + ((r % 2) * (M / 2));
        end
      endcase
    end
    r = ((r % M) + M) % M;
    x.res = r[W-1:0];
    x.fl  = {of, co, g, l, e, er};
    return x;
  endfunction

  task automatic apply(input string tag, input bit rst, input bit ce, input bit mode,
                       input bit cin, input logic [1:0] v, input logic [3:0] cmd,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    reset         = rst;
    bus.ce        = ce;
    bus.mode      = mode;
    bus.cin       = cin;
    bus.inp_valid = v;
    bus.cmd       = cmd;
    bus.opa       = a;
    bus.opb       = b;
    x = model(rst, ce, mode, cin, v, cmd, a, b);
    @(posedge clk);
    #1;
    check({tag, "_res"}, {8'h00, bus.res}, {8'h00, x.res});
    check({tag, "_flags"}, {10'h000, bus.oflow, bus.cout, bus.g, bus.l, bus.e, bus.err},
          {10'h000, x.fl});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    bus.ce = 1'b0; bus.mode = 1'b0; bus.cin = 1'b0; bus.inp_valid = 2'b00;
    bus.cmd = 4'd0; bus.opa = '0; bus.opb = '0;
    @(negedge clk);

    // Directed scenarios
    apply("rst0",     1, 1, 1, 0, 2'b11, 4'd0,  8'hFF, 8'h01);
    apply("rst1",     1, 1, 1, 0, 2'b11, 4'd0,  8'hFF, 8'h01);
    apply("ce_off",   0, 0, 1, 1, 2'b11, 4'd0,  8'hAA, 8'h55);
    apply("add",      0, 1, 1, 0, 2'b11, 4'd0,  8'h10, 8'h20);
    apply("add_wrap", 0, 1, 1, 0, 2'b11, 4'd0,  8'hFF, 8'h01);
    apply("sub_brw",  0, 1, 1, 0, 2'b11, 4'd1,  8'h05, 8'h07);
    apply("add_cin",  0, 1, 1, 1, 2'b11, 4'd2,  8'h01, 8'h01);
    apply("sub_cin",  0, 1, 1, 1, 2'b11, 4'd3,  8'h07, 8'h07);
    apply("inc_a",    0, 1, 1, 0, 2'b01, 4'd4,  8'hFF, 8'h00);
    apply("dec_b",    0, 1, 1, 0, 2'b10, 4'd7,  8'h00, 8'h00);
    apply("cmp_eq",   0, 1, 1, 0, 2'b11, 4'd8,  8'h3C, 8'h3C);
    apply("cmp_gt",   0, 1, 1, 0, 2'b11, 4'd8,  8'h40, 8'h3C);
    apply("cmp_lt",   0, 1, 1, 0, 2'b11, 4'd8,  8'h01, 8'h3C);
    apply("rol",      0, 1, 0, 0, 2'b11, 4'd12, 8'h81, 8'h01);
    apply("ror_err",  0, 1, 0, 0, 2'b11, 4'd13, 8'h01, 8'h10);
    apply("xnor",     0, 1, 0, 0, 2'b11, 4'd5,  8'hF0, 8'hFF);
    apply("shl_a",    0, 1, 0, 0, 2'b01, 4'd9,  8'hC1, 8'h00);
    apply("err_add",  0, 1, 1, 0, 2'b01, 4'd0,  8'h12, 8'h34);
    apply("err_cmd",  0, 1, 1, 0, 2'b11, 4'hF,  8'h12, 8'h34);
    apply("err_incb", 0, 1, 1, 0, 2'b01, 4'd6,  8'h12, 8'h34);
    apply("err_v00",  0, 1, 0, 0, 2'b00, 4'd6,  8'h12, 8'h34);
    apply("err_lg14", 0, 1, 0, 0, 2'b11, 4'd14, 8'h12, 8'h34);
    apply("rst_mid",  1, 1, 1, 0, 2'b11, 4'd0,  8'h33, 8'h44);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0]   v;
      logic [W-1:0] a, b;
      bit           rst, ce;
      rst = ($urandom_range(0, 19) == 0);
      ce  = ($urandom_range(0, 9) != 0);
      v   = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      a   = 8'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) a = b;
      apply("rnd", rst, ce, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            v, 4'($urandom_range(0, 15)), a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
